// File: rtl/wb_arbiter.sv
// Writeback arbiter for the integer register file: merges ALU results with buffered
// long-latency results and tracks pending long-latency destinations for decode stalls.
module wb_arbiter #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [31:0] SP_RESET   = 32'h1000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          alu_valid_i,
   input  logic [4:0]                    alu_rd_addr_i,
   input  logic [31:0]                   alu_rd_data_i,
   input  logic                          long_valid_i,
   output logic                          long_ready_o,
   input  logic [4:0]                    long_rd_addr_i,
   input  logic [31:0]                   long_rd_data_i,
   input  logic                          issue_long_i,
   input  logic [4:0]                    issue_rd_i,
   input  logic [4:0]                    dec_rs1_i,
   input  logic [4:0]                    dec_rs2_i,
   input  logic [4:0]                    dec_rd_i,
   output logic                          stall_o,
   output logic                          wr_en_o,
   output logic [4:0]                    rd_addr_o,
   output logic [31:0]                   rd_data_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end
   if (SP_RESET[1:0] != 2'b00) begin : g_bad_sp
      $error("SP_RESET must be word aligned");
   end

   logic [4:0]        fifo_rd   [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [31:0]       busy;
   logic [31:0]       busy_next;
   logic              push;
   logic              pop;
   logic              wr_en_p1;
   logic [4:0]        rd_addr_p1;
   logic [DATA_W-1:0] rd_data_p1;

   // Ready and pop both look only at registered occupancy, so a fresh push never pops early.
   assign long_ready_o = (count < DEPTH_C);
   assign push         = long_valid_i && long_ready_o;
   assign pop          = !alu_valid_i && (count != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= long_rd_addr_i;
         fifo_data[wr_ptr] <= long_rd_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Clear first, then set, so a re-issue on the retiring edge keeps the register busy.
   always_comb begin
      busy_next = busy;
      if (pop) busy_next[fifo_rd[rd_ptr]] = 1'b0;
      if (issue_long_i && (issue_rd_i != 5'd0)) busy_next[issue_rd_i] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else     busy <= busy_next;
   end

   // Writeback output stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_p1   <= 1'b0;
         rd_addr_p1 <= '0;
         rd_data_p1 <= '0;
      end else if (alu_valid_i) begin
         wr_en_p1   <= (alu_rd_addr_i != 5'd0);
         rd_addr_p1 <= alu_rd_addr_i;
         rd_data_p1 <= alu_rd_data_i;
      end else if (pop) begin
         wr_en_p1   <= (fifo_rd[rd_ptr] != 5'd0);
         rd_addr_p1 <= fifo_rd[rd_ptr];
         rd_data_p1 <= fifo_data[rd_ptr];
      end else begin
         wr_en_p1   <= 1'b0;
      end
   end

   assign wr_en_o      = wr_en_p1;
   assign rd_addr_o    = rd_addr_p1;
   assign rd_data_o    = rd_data_p1;
   assign fifo_count_o = count;
   assign stall_o      = busy[dec_rs1_i] | busy[dec_rs2_i] | busy[dec_rd_i];

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_arbiter;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid_i;
   logic [4:0]  alu_rd_addr_i;
   logic [31:0] alu_rd_data_i;
   logic        long_valid_i;
   logic        long_ready_o;
   logic [4:0]  long_rd_addr_i;
   logic [31:0] long_rd_data_i;
   logic        issue_long_i;
   logic [4:0]  issue_rd_i;
   logic [4:0]  dec_rs1_i;
   logic [4:0]  dec_rs2_i;
   logic [4:0]  dec_rd_i;
   logic        stall_o;
   logic        wr_en_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] rd_data_o;
   logic [$clog2(DEPTH):0] fifo_count_o;

   wb_arbiter #(.FIFO_DEPTH(DEPTH), .SP_RESET(32'h1000)) dut (
      .clk(clk), .rst(rst),
      .alu_valid_i(alu_valid_i), .alu_rd_addr_i(alu_rd_addr_i), .alu_rd_data_i(alu_rd_data_i),
      .long_valid_i(long_valid_i), .long_ready_o(long_ready_o),
      .long_rd_addr_i(long_rd_addr_i), .long_rd_data_i(long_rd_data_i),
      .issue_long_i(issue_long_i), .issue_rd_i(issue_rd_i),
      .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
      .stall_o(stall_o), .wr_en_o(wr_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
      .fifo_count_o(fifo_count_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] d;
   } res_t;

   res_t        q[$];
   bit   [31:0] mbusy;
   logic        exp_wr;
   logic [4:0]  exp_addr;
   logic [31:0] exp_data;
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_chk++;
      if (obs !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, want);
      end
   endtask

   task automatic model_reset();
      q.delete();
      mbusy    = '0;
      exp_wr   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
   endtask

   // One clock edge of the reference behaviour, using the inputs present before the edge.
   task automatic model_edge();
      bit   acc;
      res_t e;
      acc = long_valid_i && (q.size() < DEPTH);
      if (alu_valid_i) begin
         exp_wr   = (alu_rd_addr_i != 0);
         exp_addr = alu_rd_addr_i;
         exp_data = alu_rd_data_i;
      end else if (q.size() > 0) begin
         e        = q.pop_front();
         exp_wr   = (e.rd != 0);
         exp_addr = e.rd;
         exp_data = e.d;
         mbusy[e.rd] = 1'b0;
      end else begin
         exp_wr = 1'b0;
      end
      if (issue_long_i && issue_rd_i != 0) mbusy[issue_rd_i] = 1'b1;
      if (acc) begin
         e.rd = long_rd_addr_i;
         e.d  = long_rd_data_i;
         q.push_back(e);
      end
   endtask

   task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd);
      @(negedge clk);
      alu_valid_i = av; alu_rd_addr_i = ard; alu_rd_data_i = ad;
      long_valid_i = lv; long_rd_addr_i = lrd; long_rd_data_i = ld;
      issue_long_i = iv; issue_rd_i = ird;
      dec_rs1_i = r1; dec_rs2_i = r2; dec_rd_i = rdd;
      #1;
      chk("stall", {31'b0, stall_o}, {31'b0, mbusy[r1] | mbusy[r2] | mbusy[rdd]});
      chk("ready", {31'b0, long_ready_o}, {31'b0, q.size() < DEPTH});
      chk("count", 32'(fifo_count_o), 32'(q.size()));
      @(posedge clk);
      model_edge();
      #1;
      chk("wr_en", {31'b0, wr_en_o}, {31'b0, exp_wr});
      chk("rd_addr", {27'b0, rd_addr_o}, {27'b0, exp_addr});
      chk("rd_data", rd_data_o, exp_data);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int pct;
      rst = 1'b1;
      alu_valid_i = 0; alu_rd_addr_i = 0; alu_rd_data_i = 0;
      long_valid_i = 0; long_rd_addr_i = 0; long_rd_data_i = 0;
      issue_long_i = 0; issue_rd_i = 0;
      dec_rs1_i = 0; dec_rs2_i = 0; dec_rd_i = 0;
      model_reset();
      #3;
      chk("rst_wr_en", {31'b0, wr_en_o}, 32'd0);
      chk("rst_addr", {27'b0, rd_addr_o}, 32'd0);
      chk("rst_data", rd_data_o, 32'd0);
      chk("rst_count", 32'(fifo_count_o), 32'd0);
      chk("rst_ready", {31'b0, long_ready_o}, 32'd1);
      chk("rst_stall", {31'b0, stall_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // ALU path: one-cycle latency, then address/data hold with wr_en low
      cycle(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("alu_wr", {31'b0, wr_en_o}, 32'd1);
      chk("alu_addr", {27'b0, rd_addr_o}, 32'd3);
      chk("alu_data", rd_data_o, 32'hDEADBEEF);
      idle();
      chk("alu_once", {31'b0, wr_en_o}, 32'd0);
      chk("alu_hold", rd_data_o, 32'hDEADBEEF);

      // Long result buffered behind a 3-cycle ALU stream
      cycle(1, 1, 32'h100, 1, 7, 32'h11, 0, 0, 0, 0, 0);
      chk("buf_count", 32'(fifo_count_o), 32'd1);
      cycle(1, 2, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 6, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      chk("buf_wr", {31'b0, wr_en_o}, 32'd1);
      chk("buf_addr", {27'b0, rd_addr_o}, 32'd7);
      chk("buf_data", rd_data_o, 32'h11);

      // FIFO full, third offer refused, in-order drain
      cycle(1, 1, 32'h1, 1, 10, 32'hA0, 0, 0, 0, 0, 0);
      cycle(1, 1, 32'h2, 1, 11, 32'hB0, 0, 0, 0, 0, 0);
      chk("full_ready", {31'b0, long_ready_o}, 32'd0);
      cycle(1, 1, 32'h3, 1, 12, 32'hC0, 0, 0, 0, 0, 0);
      chk("full_count", 32'(fifo_count_o), 32'd2);
      cycle(0, 0, 0, 1, 12, 32'hC0, 0, 0, 0, 0, 0);
      chk("drain1_addr", {27'b0, rd_addr_o}, 32'd10);
      chk("drain1_ready", {31'b0, long_ready_o}, 32'd1);
      idle();
      chk("drain2_addr", {27'b0, rd_addr_o}, 32'd11);
      chk("drain2_data", rd_data_o, 32'hB0);
      idle();
      chk("drain_empty", {31'b0, wr_en_o}, 32'd0);

      // Scoreboard stall until the pop of x9 retires
      cycle(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
      cycle(1, 2, 32'h5, 1, 9, 32'h99, 0, 0, 9, 0, 0);
      chk("sb_stall", {31'b0, stall_o}, 32'd1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
      chk("sb_release", {31'b0, stall_o}, 32'd0);
      chk("sb_wr", {31'b0, wr_en_o}, 32'd1);
      chk("sb_addr", {27'b0, rd_addr_o}, 32'd9);

      // x0 long result never writes
      cycle(0, 0, 0, 1, 0, 32'h5, 0, 0, 0, 0, 0);
      idle();
      chk("x0_wr", {31'b0, wr_en_o}, 32'd0);
      chk("x0_data", rd_data_o, 32'h5);

      // Set and clear of x4 on the same edge keeps it busy
      cycle(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
      cycle(1, 8, 32'h8, 1, 4, 32'h44, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0);
      chk("setclr_busy", {31'b0, stall_o}, 32'd1);

      // Asynchronous reset mid-cycle with one entry buffered and x5 busy
      cycle(1, 1, 32'h77, 1, 5, 32'h55, 1, 5, 0, 0, 0);
      @(negedge clk);
      alu_valid_i = 0; long_valid_i = 0; issue_long_i = 0;
      dec_rs1_i = 5; dec_rs2_i = 0; dec_rd_i = 0;
      #1;
      chk("prerst_stall", {31'b0, stall_o}, 32'd1);
      chk("prerst_count", 32'(fifo_count_o), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("arst_wr_en", {31'b0, wr_en_o}, 32'd0);
      chk("arst_count", 32'(fifo_count_o), 32'd0);
      chk("arst_ready", {31'b0, long_ready_o}, 32'd1);
      chk("arst_stall", {31'b0, stall_o}, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      dec_rs1_i = 0;

      // Randomized traffic with phases of varying ALU pressure
      for (int i = 0; i < 3000; i++) begin
         case ((i / 150) % 4)
            0:       pct = 100;
            1:       pct = 50;
            2:       pct = 15;
            default: pct = 80;
         endcase
         cycle($urandom_range(0, 99) < pct, 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
